// File: rtl/dec_scan_if.sv
// dec_scan_if: control/output bundle for the registered scanning decoder.
// master drives enable, mode and select; slave returns the decoded lines,
// the current index and the wrap pulse.
interface dec_scan_if #(parameter int SEL_W = 2);
  logic                  e;
  logic                  mode;
  logic [SEL_W-1:0]      a;
  logic [(2**SEL_W)-1:0] y;
  logic [SEL_W-1:0]      idx;
  logic                  wrap;

  modport master (output e, mode, a, input  y, idx, wrap);
  modport slave  (input  e, mode, a, output y, idx, wrap);
endinterface

// File: rtl/dec_scan.sv
// dec_scan: registered N-to-2^N one-hot decoder with enable and auto-scan.
// Direct mode decodes a; scan mode walks the active line through all outputs,
// holding each for DWELL cycles and pulsing wrap when the index returns to 0.
// Optional build macro DEC_ACTIVE_LOW_EN: y is driven inverted (idle = all
// ones, active line = single 0); idx, wrap and timing are unaffected.
module dec_scan #(
  parameter int SEL_W = 2,
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  dec_scan_if.slave  bus
);
  localparam int NL    = 2**SEL_W;
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

`ifdef DEC_ACTIVE_LOW_EN
  localparam logic POL = 1'b1;
`else
  localparam logic POL = 1'b0;
`endif

  logic             r_mode_q;
  logic [SEL_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_wrap;
  logic [NL-1:0]    r_y;

  logic             w_entry;
  logic [SEL_W-1:0] w_idx_n;
  logic [CNT_W-1:0] w_cnt_n;
  logic             w_wrap_n;
  logic             w_act_n;
  logic [NL-1:0]    w_hot;

  assign w_entry = bus.mode & ~r_mode_q;

  // Next index/dwell/wrap in priority order: scan entry, disable, direct, scan.
  always_comb begin
    w_idx_n  = r_idx;
    w_cnt_n  = r_cnt;
    w_wrap_n = 1'b0;
    w_act_n  = 1'b0;
    if (w_entry) begin
      // Entry loads the start index even while disabled so the scan begins at a.
      w_idx_n = bus.a;
      w_cnt_n = '0;
      w_act_n = bus.e;
    end else if (!bus.e) begin
      // Disabled: outputs go idle, index and dwell count freeze mid-dwell.
      w_act_n = 1'b0;
    end else if (!bus.mode) begin
      w_idx_n = bus.a;
      w_cnt_n = '0;
      w_act_n = 1'b1;
    end else begin
      w_act_n = 1'b1;
      if (r_cnt == CNT_LAST) begin
        w_cnt_n  = '0;
        w_idx_n  = r_idx + 1'b1;
        w_wrap_n = &r_idx;
      end else begin
        w_cnt_n = r_cnt + 1'b1;
      end
    end
  end

  // One-hot of the next index so y and idx always agree in the same cycle.
  always_comb begin
    w_hot = '0;
    if (w_act_n) w_hot = NL'(1) << w_idx_n;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode_q <= 1'b0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_wrap   <= 1'b0;
      r_y      <= {NL{POL}};
    end else begin
      r_mode_q <= bus.mode;
      r_idx    <= w_idx_n;
      r_cnt    <= w_cnt_n;
      r_wrap   <= w_wrap_n;
      r_y      <= w_hot ^ {NL{POL}};
    end
  end

  assign bus.y    = r_y;
  assign bus.idx  = r_idx;
  assign bus.wrap = r_wrap;
endmodule

// File: tb/tb_dec_scan.sv
// tb_dec_scan: three decoders (SEL_W=2, DWELL=3/4/1) share one stimulus
// stream. A sweep-position model checks every cycle; a vector table and
// hand-written sequences cover the documented corner cases.
module tb_dec_scan;
  logic clk = 1'b0;
  logic rst, e, mode;
  logic [1:0] a;
  always #5 clk = ~clk;

  dec_scan_if #(.SEL_W(2)) if3 ();
  dec_scan_if #(.SEL_W(2)) if4 ();
  dec_scan_if #(.SEL_W(2)) if1 ();
  assign if3.e = e; assign if3.mode = mode; assign if3.a = a;
  assign if4.e = e; assign if4.mode = mode; assign if4.a = a;
  assign if1.e = e; assign if1.mode = mode; assign if1.a = a;

  dec_scan #(.SEL_W(2), .DWELL(3)) u3 (.clk(clk), .rst(rst), .bus(if3));
  dec_scan #(.SEL_W(2), .DWELL(4)) u4 (.clk(clk), .rst(rst), .bus(if4));
  dec_scan #(.SEL_W(2), .DWELL(1)) u1 (.clk(clk), .rst(rst), .bus(if1));

  logic [3:0] yo [3];
  logic [1:0] io [3];
  logic       wo [3];
  assign yo[0] = if3.y; assign io[0] = if3.idx; assign wo[0] = if3.wrap;
  assign yo[1] = if4.y; assign io[1] = if4.idx; assign wo[1] = if4.wrap;
  assign yo[2] = if1.y; assign io[2] = if1.idx; assign wo[2] = if1.wrap;

  int npass = 0;
  int ntot  = 0;

  function automatic logic [3:0] pol(input logic [3:0] v);
`ifdef DEC_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else npass++;
  endtask

  // Reference model: position within a full sweep (line*DWELL + elapsed dwell).
  int   dw [3] = '{3, 4, 1};
  int   pos [3] = '{0, 0, 0};
  logic act [3] = '{1'b0, 1'b0, 1'b0};
  logic wr  [3] = '{1'b0, 1'b0, 1'b0};
  logic mq = 1'b0;
  logic mon = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int nx;
      nx = (pos[k] + 1) % (dw[k] * 4);
      if (rst) begin
        pos[k] <= 0; act[k] <= 1'b0; wr[k] <= 1'b0;
      end else if (mode && !mq) begin
        pos[k] <= int'(a) * dw[k]; act[k] <= e; wr[k] <= 1'b0;
      end else if (!e) begin
        act[k] <= 1'b0; wr[k] <= 1'b0;
      end else if (!mode) begin
        pos[k] <= int'(a) * dw[k]; act[k] <= 1'b1; wr[k] <= 1'b0;
      end else begin
        pos[k] <= nx; act[k] <= 1'b1; wr[k] <= (nx == 0);
      end
    end
    mq <= rst ? 1'b0 : mode;
  end

  always @(negedge clk) begin
    if (mon) begin
      for (int k = 0; k < 3; k++) begin
        int li;
        li = pos[k] / dw[k];
        chk($sformatf("model_y[%0d]", k), 32'(yo[k]), 32'(pol(act[k] ? 4'(1 << li) : 4'h0)));
        chk($sformatf("model_idx[%0d]", k), 32'(io[k]), 32'(li));
        chk($sformatf("model_wrap[%0d]", k), 32'(wo[k]), 32'(wr[k]));
      end
    end
  end

  // Apply inputs for one cycle; outputs are sampled at the following negedge.
  task automatic drv(input logic r, input logic en, input logic m, input logic [1:0] sel);
    rst = r; e = en; mode = m; a = sel;
    @(negedge clk);
  endtask

  task automatic chk_inst(input string nm, input int k, input logic [3:0] ey,
                          input logic [1:0] ei, input logic ew);
    chk({nm, "_y"}, 32'(yo[k]), 32'(pol(ey)));
    chk({nm, "_idx"}, 32'(io[k]), 32'(ei));
    chk({nm, "_wrap"}, 32'(wo[k]), 32'(ew));
  endtask

  typedef struct {
    logic r, e, m;
    logic [1:0] a;
    logic [3:0] y;
    logic [1:0] idx;
    logic w;
  } vec_t;
  vec_t tbl [$];

  function automatic vec_t mk(logic r, logic en, logic m, logic [1:0] sel,
                              logic [3:0] y, logic [1:0] idx, logic w);
    vec_t v;
    v.r = r; v.e = en; v.m = m; v.a = sel; v.y = y; v.idx = idx; v.w = w;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; e = 1'b0; mode = 1'b0; a = 2'd0;
    @(negedge clk);
    mon = 1'b1;

    // Direct decode, enable gating, DWELL=3 sweep from a=1, exit, disabled entry.
    tbl.push_back(mk(1,0,0,0, 4'b0000,0,0));
    tbl.push_back(mk(0,1,0,0, 4'b0001,0,0));
    tbl.push_back(mk(0,1,0,1, 4'b0010,1,0));
    tbl.push_back(mk(0,1,0,2, 4'b0100,2,0));
    tbl.push_back(mk(0,1,0,3, 4'b1000,3,0));
    tbl.push_back(mk(0,1,0,2, 4'b0100,2,0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,0,0,2, 4'b0000,2,0));
    tbl.push_back(mk(0,1,0,2, 4'b0100,2,0));
    tbl.push_back(mk(0,1,1,1, 4'b0010,1,0));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(0,1,1,0, 4'b0010,1,0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,1,1,3, 4'b0100,2,0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,1,1,0, 4'b1000,3,0));
    tbl.push_back(mk(0,1,1,0, 4'b0001,0,1));
    tbl.push_back(mk(0,1,1,0, 4'b0001,0,0));
    tbl.push_back(mk(0,1,0,3, 4'b1000,3,0));
    tbl.push_back(mk(1,1,0,0, 4'b0000,0,0));
    tbl.push_back(mk(0,0,1,2, 4'b0000,2,0));
    tbl.push_back(mk(0,1,1,0, 4'b0100,2,0));
    foreach (tbl[i]) begin
      drv(tbl[i].r, tbl[i].e, tbl[i].m, tbl[i].a);
      chk_inst($sformatf("tbl%0d", i), 0, tbl[i].y, tbl[i].idx, tbl[i].w);
    end

    // Freeze mid-dwell on the DWELL=4 instance.
    drv(1,0,0,0);
    drv(0,1,1,2); chk_inst("frz_entry", 1, 4'b0100, 2, 0);
    drv(0,1,1,0); chk_inst("frz_dw2", 1, 4'b0100, 2, 0);
    for (int i = 0; i < 5; i++) begin
      drv(0,0,1,0); chk_inst("frz_off", 1, 4'b0000, 2, 0);
    end
    drv(0,1,1,0); chk_inst("frz_re1", 1, 4'b0100, 2, 0);
    drv(0,1,1,0); chk_inst("frz_re2", 1, 4'b0100, 2, 0);
    drv(0,1,1,0); chk_inst("frz_adv", 1, 4'b1000, 3, 0);

    // Reset mid-scan with mode held high, DWELL=1 instance.
    drv(0,1,1,1);
    drv(1,1,1,0); chk_inst("rst_mid", 2, 4'b0000, 0, 0);
    drv(0,1,1,3); chk_inst("rst_entry", 2, 4'b1000, 3, 0);
    drv(0,1,1,0); chk_inst("rst_wrap", 2, 4'b0001, 0, 1);
    drv(0,1,1,0); chk_inst("rst_next", 2, 4'b0010, 1, 0);

    // Randomized traffic; the model checker covers every cycle.
    mode = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic m;
      m = mode;
      if ($urandom_range(15) == 0) m = ~m;
      drv(($urandom_range(49) == 0), ($urandom_range(7) != 0), m, 2'($urandom_range(3)));
    end

    mon = 1'b0;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
